// File: rtl/emit2_cnt_dp.sv
// Datapath/responder side of the emit-2 counter handshake: owns the pour-unit
// down-counter, times each unit with a prescaler and answers count2 with count_ACK2.
module emit2_cnt_dp #(
   parameter int CNT_W    = 8,
   parameter int TICK_DIV = 50000,
   parameter int DIV_W    = 16
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             cnt2_ld,
   input  logic             cnt2_clr,
   input  logic             cnt2_ACK,
   input  logic             count2,
   input  logic [CNT_W-1:0] load_val,
   output logic             count_ACK2,
   output logic             eq_0,
   output logic             valve2,
   output logic [CNT_W-1:0] remain2,
   output logic             done2
);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_RUN  = 2'd1,
      R_ACK  = 2'd2
   } rstate_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   rstate_t          state;
   rstate_t          state_next;
   logic [CNT_W-1:0] cnt;
   logic [DIV_W-1:0] div;

   always_ff @(posedge clk) begin
      if (RESET || cnt2_clr) begin
         state <= R_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An empty counter still gets an acknowledge, so the controller never stalls.
   always_comb begin
      state_next = state;
      count_ACK2 = 1'b0;
      valve2     = 1'b0;
      case (state)
         R_IDLE: begin
            if (count2) begin
               state_next = (cnt != '0) ? R_RUN : R_ACK;
            end
         end
         R_RUN: begin
            valve2 = 1'b1;
            if (div == DIV_LAST) begin
               state_next = R_ACK;
            end
         end
         R_ACK: begin
            count_ACK2 = 1'b1;
            if (!count2) begin
               state_next = R_IDLE;
            end
         end
         default: begin
            state_next = R_IDLE;
         end
      endcase
   end

   // A load arriving together with count2 only changes cnt; the start decision
   // above has already been taken from the pre-load value.
   always_ff @(posedge clk) begin
      if (RESET || cnt2_clr) begin
         cnt   <= '0;
         div   <= '0;
         done2 <= 1'b0;
      end else begin
         done2 <= 1'b0;
         case (state)
            R_IDLE: begin
               div <= '0;
               if (cnt2_ld && !cnt2_ACK) begin
                  cnt <= load_val;
               end
            end
            R_RUN: begin
               if (div == DIV_LAST) begin
                  div <= '0;
                  if (cnt != '0) begin
                     cnt   <= cnt - CNT_W'(1);
                     done2 <= (cnt == CNT_W'(1));
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            default: begin
               div <= '0;
            end
         endcase
      end
   end

   assign eq_0    = (cnt == '0);
   assign remain2 = cnt;

endmodule

// File: tb/tb_emit2_cnt_dp.sv
// Self-checking bench for emit2_cnt_dp: vector table, directed handshake
// sequences and randomized traffic against a cycle-level reference model.
module tb_emit2_cnt_dp;

   localparam int TICK = 4;

   logic       clk = 1'b0;
   logic       RESET = 1'b0;
   logic       cnt2_ld = 1'b0;
   logic       cnt2_clr = 1'b0;
   logic       cnt2_ACK = 1'b0;
   logic       count2 = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       count_ACK2;
   logic       eq_0;
   logic       valve2;
   logic [7:0] remain2;
   logic       done2;

   int tests = 0;
   int fails = 0;
   int warns = 0;
   int valve_seen = 0;
   int done_seen = 0;
   int ack_seen = 0;

   // Reference model: units left to pour, remaining valve cycles of the
   // current unit, and whether an acknowledge is being held.
   logic [7:0] m_cnt = 8'd0;
   int         m_pour = 0;
   logic       m_ack = 1'b0;
   logic       m_done = 1'b0;

   typedef struct {
      logic       rst, clr, ld, cack, c2;
      logic [7:0] lv;
      logic       e_ack, e_valve, e_eq0;
      logic [7:0] e_rem;
      logic       e_done;
   } vec_t;

   vec_t vecs[20];

   emit2_cnt_dp #(.CNT_W(8), .TICK_DIV(TICK), .DIV_W(16)) dut (
      .clk(clk),
      .RESET(RESET),
      .cnt2_ld(cnt2_ld),
      .cnt2_clr(cnt2_clr),
      .cnt2_ACK(cnt2_ACK),
      .count2(count2),
      .load_val(load_val),
      .count_ACK2(count_ACK2),
      .eq_0(eq_0),
      .valve2(valve2),
      .remain2(remain2),
      .done2(done2)
   );

   always #5 clk = ~clk;

   task automatic modelStep();
      if (RESET || cnt2_clr) begin
         m_cnt  = 8'd0;
         m_pour = 0;
         m_ack  = 1'b0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_pour > 0) begin
            m_pour = m_pour - 1;
            if (m_pour == 0) begin
               if (m_cnt > 0) begin
                  m_cnt  = m_cnt - 8'd1;
                  m_done = (m_cnt == 0);
               end
               m_ack = 1'b1;
            end
         end else if (m_ack) begin
            if (!count2) m_ack = 1'b0;
         end else begin
            if (count2 && cnt2_ld && !cnt2_ACK) warns++;
            if (count2) begin
               if (m_cnt > 0) m_pour = TICK;
               else m_ack = 1'b1;
            end
            if (cnt2_ld && !cnt2_ACK) m_cnt = load_val;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic ea, input logic ev,
                              input logic ee, input logic [7:0] er, input logic ed);
      tests++;
      if ({count_ACK2, valve2, eq_0, remain2, done2} !== {ea, ev, ee, er, ed}) begin
         fails++;
         $display("[TB] FAIL %s: ack/valve/eq0/remain/done got %b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
                  name, count_ACK2, valve2, eq_0, remain2, done2, ea, ev, ee, er, ed);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic clr, input logic ld,
                                input logic cack, input logic c2, input logic [7:0] lv);
      RESET    = rst;
      cnt2_clr = clr;
      cnt2_ld  = ld;
      cnt2_ACK = cack;
      count2   = c2;
      load_val = lv;
   endtask

   // One clock: advance the model with the current inputs, then compare after the edge.
   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
      checkOutput("model", m_ack, (m_pour > 0), (m_cnt == 0), m_cnt, m_done);
      if (valve2) valve_seen++;
      if (done2) done_seen++;
      if (count_ACK2) ack_seen++;
   endtask

   task automatic waitAck(input logic level, input string name);
      for (int k = 0; k < 40 && count_ACK2 !== level; k++) tick();
      checkValue(name, int'(count_ACK2), int'(level));
   endtask

   initial begin
      int units;
      int unit_valve;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].cack, vecs[i].c2, vecs[i].lv);
         tick();
         checkOutput($sformatf("table[%0d]", i), vecs[i].e_ack, vecs[i].e_valve,
                     vecs[i].e_eq0, vecs[i].e_rem, vecs[i].e_done);
      end

      // Full controller sequence with three units.
      valve_seen = 0;
      done_seen  = 0;
      units      = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      tick();
      while (units < 6 && !eq_0) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
         unit_valve = valve_seen;
         waitAck(1'b1, "unit_ack");
         units++;
         checkValue("unit_valve", valve_seen - unit_valve, TICK);
         checkValue("remain_step", int'(remain2), 3 - units);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
         waitAck(1'b0, "unit_ack_drop");
      end
      checkValue("units", units, 3);
      checkValue("valve_total", valve_seen, 3 * TICK);
      checkValue("done_pulses", done_seen, 1);
      checkValue("eq0_end", int'(eq_0), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
      tick();

      // Zero load: immediate acknowledge, no pouring.
      valve_seen = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      tick();
      checkOutput("zero_ack", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick();
      checkValue("zero_valve", valve_seen, 0);

      // Abort two cycles into a unit.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
      tick();
      checkOutput("abort", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
      ack_seen   = 0;
      valve_seen = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
      for (int k = 0; k < 6; k++) tick();
      checkValue("abort_no_ack", ack_seen, 0);
      checkValue("abort_no_valve", valve_seen, 0);

      // Handshake hold followed by no reload in WAIT.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
      waitAck(1'b1, "hold_ack");
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput("hold", 1'b1, 1'b0, 1'b0, 8'd3, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd9);
      tick();
      checkValue("ack_drop", int'(count_ACK2), 0);
      for (int k = 0; k < 3; k++) tick();
      checkValue("no_reload", int'(remain2), 3);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      tick();

      // Randomized traffic against the model.
      warns = 0;
      for (int n = 0; n < 3000; n++) begin
         logic c2;
         c2 = count2;
         if ($urandom_range(0, 5) == 0) c2 = ~c2;
         applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), c2,
                       8'($urandom_range(0, 5)));
         tick();
      end
      $display("[TB] protocol warnings (count2 with load in idle): %0d", warns);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
